jump_flush_controller: RTL and testbench
========================================

// Module: jump_flush_controller
// PURPOSE
//  Sequences control-flow changes in the 5-stage RISC pipeline.
//  - Owns the condition-code register (CCR: Z,N,C) and evaluates JMP/JZ/JN/JC in EX against forwarded flags.
//  - On a taken jump: redirects the PC, flushes the younger stages for FLUSH_CYCLES cycles,
//    clears the consumed flag, and counts taken jumps.
// PARAMETERS
//  ADDR_W        16  width of PC / jump target
//  FLUSH_CYCLES  2   cycles flush is held after a taken jump (1..7)
//  CNT_W         16  width of saturating taken-jump counter
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       synchronous, active-high reset
//  jmp_valid    in   1       EX holds a jump instr this cycle
//  jmp          in   1       unconditional jump
//  jz           in   1       jump if Z
//  jn           in   1       jump if N
//  jc           in   1       jump if C
//  jmp_target   in   ADDR_W  target address from EX
//  flags_we     in   1       ALU writes flags this cycle
//  flags_in     in   3       {Z,N,C} from ALU
//  stall_in     in   1       pipeline frozen by hazard unit
//  ccr          out  3       current {Z,N,C}
//  pc_sel       out  1       1 = fetch from pc_target
//  pc_target    out  ADDR_W  registered redirect address
//  flush        out  1       kill IF/ID and ID/EX contents
//  busy         out  1       FSM not in IDLE
//  taken_cnt    out  CNT_W   taken jumps since reset, saturating
// BEHAVIOUR
//  Reset
//  - All outputs reset to 0; ccr=3'b000; FSM=IDLE; flush counter=0.
//  Flag forwarding
//  - eff = flags_we ? flags_in : ccr.
//  - Decision is combinational:
//    take = jmp | (jz & eff.Z) | (jn & eff.N) | (jc & eff.C).
//  - Multiple condition bits may be set; the decision is their OR.
//  Accept
//  - A request is accepted only when jmp_valid & !stall_in & FSM==IDLE.
//  - Requests arriving in FLUSH are ignored; they are wrong-path instructions.
//  CCR update at each edge
//  - First: if flags_we & !stall_in, ccr<=flags_in.
//  - Then, for an accepted taken request: clear each flag whose condition bit is set and which was 1 in eff.
//  - JMP never alters ccr. Not-taken jumps never alter ccr.
//  FSM IDLE
//  - Accepted & take -> FLUSH.
//  - On that edge: pc_target<=jmp_target; pc_sel<=1; flush<=1; cnt<=FLUSH_CYCLES-1;
//    taken_cnt+=1, saturating at all-ones.
//  - Not taken or no request -> stay in IDLE; outputs 0.
//  FSM FLUSH
//  - pc_sel is high exactly on the first FLUSH cycle only. flush and busy stay high.
//  - Each non-stalled cycle: if cnt==0 -> IDLE (flush, busy <= 0), else cnt-=1.
//  - Result: flush is high for exactly FLUSH_CYCLES non-stalled cycles. Latency request->pc_sel is 1 cycle.
//  Stall
//  - stall_in freezes the FSM, cnt, pc_sel, flush and ccr writes. All outputs hold their values.
//  - taken_cnt does not increment while stalled.
//  - pc_sel remains high if the stall lands on the first FLUSH cycle.
//  Reset mid-operation
//  - rst in FLUSH forces IDLE immediately at that edge; pc_sel=flush=0.
//  - Any pending redirect is dropped.
//  Saturation
//  - taken_cnt stops at {CNT_W{1'b1}}; there is no wrap.
// TESTING
//  T1
//  - Stimulus: rst 1 cycle, then jmp_valid=1, jmp=1, target=16'h0040.
//  - Required: next cycle pc_sel=1, pc_target=0x0040, flush=1; flush high 2 cycles total;
//    taken_cnt=1; ccr unchanged 000.
//  T2
//  - Stimulus: flags_we=1, flags_in=100 (Z), same cycle jz=1 valid.
//  - Required: taken (forwarded); ccr ends 000; pc_sel pulses.
//  - Stimulus: jc=1 with ccr=000.
//  - Required: no pc_sel, no flush, taken_cnt unchanged.
//  T3
//  - Stimulus: ccr=011 (N,C), jn=1 & jc=1 valid.
//  - Required: taken; ccr -> 000.
//  - Stimulus: second jmp_valid during FLUSH.
//  - Required: ignored; taken_cnt increments only once.
//  T4
//  - Stimulus: taken jmp, stall_in=1 for 3 cycles starting the first FLUSH cycle.
//  - Required: pc_sel held 4 cycles; flush stays high for 2 unstalled cycles afterward.
//  T5
//  - Stimulus: taken jmp, rst on the first FLUSH cycle.
//  - Required: next cycle all outputs 0, busy=0, ccr=000.
//  - Stimulus: CNT_W=4, 17 taken jumps.
//  - Required: taken_cnt=4'hF.

Source files
------------

// File: rtl/jump_flush_controller.sv
// ---------------------------------------------------------------------------
// jump_flush_controller
//
// Purpose:
//   Sequences control-flow changes in a 5-stage RISC pipeline. Owns the
//   condition-code register (CCR = {Z,N,C}) and resolves JMP/JZ/JN/JC in EX
//   against forwarded ALU flags. A taken jump redirects the PC (one-cycle
//   pc_sel pulse), holds flush for FLUSH_CYCLES non-stalled cycles, clears
//   the flags it consumed, and bumps a saturating taken-jump counter.
//
// Handshake:
//   There is no ready output. A jump request (jmp_valid) is accepted only in
//   the cycle where jmp_valid & !stall_in & state==IDLE; requests seen while
//   busy are wrong-path instructions and are dropped, not queued.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   jmp_valid        EX holds a jump instruction this cycle
//   jmp, jz, jn, jc  unconditional / conditional jump kinds (may be combined)
//   jmp_target       target address from EX
//   flags_we         ALU writes flags this cycle
//   flags_in         {Z,N,C} from ALU
//   stall_in         pipeline frozen by hazard unit
//   ccr              current {Z,N,C}
//   pc_sel           1 = fetch from pc_target
//   pc_target        registered redirect address
//   flush            kill IF/ID and ID/EX contents
//   busy             FSM not in IDLE (exposes FSM state)
//   taken_cnt        taken jumps since reset, saturating
// ---------------------------------------------------------------------------
module jump_flush_controller #(
    parameter int ADDR_W       = 16,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jmp_valid,
    input  logic              jmp,
    input  logic              jz,
    input  logic              jn,
    input  logic              jc,
    input  logic [ADDR_W-1:0] jmp_target,
    input  logic              flags_we,
    input  logic [2:0]        flags_in,
    input  logic              stall_in,
    output logic [2:0]        ccr,
    output logic              pc_sel,
    output logic [ADDR_W-1:0] pc_target,
    output logic              flush,
    output logic              busy,
    output logic [CNT_W-1:0]  taken_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [2:0]       CNT_INIT = 3'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              pc_sel_q, pc_sel_d;
    logic [ADDR_W-1:0] pc_target_q, pc_target_d;
    logic              flush_q, flush_d;
    logic [2:0]        ccr_q, ccr_d;
    logic [CNT_W-1:0]  taken_cnt_q, taken_cnt_d;

    logic [2:0]        eff;
    logic              take;
    logic              accept;

    // Flags forwarded from the ALU in the same cycle win over the CCR.
    assign eff    = flags_we ? flags_in : ccr_q;
    assign take   = jmp | (jz & eff[2]) | (jn & eff[1]) | (jc & eff[0]);
    assign accept = jmp_valid & ~stall_in & (state_q == IDLE);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_sel_d    = pc_sel_q;
        pc_target_d = pc_target_q;
        flush_d     = flush_q;
        ccr_d       = ccr_q;
        taken_cnt_d = taken_cnt_q;

        // A stall freezes everything, including the first-cycle pc_sel.
        if (!stall_in) begin
            if (flags_we) begin
                ccr_d = flags_in;
            end
            case (state_q)
                IDLE: begin
                    if (accept && take) begin
                        // Consume only the flags a set condition bit tested
                        // true; the JMP bit has no flag and clears nothing.
                        ccr_d       = ccr_d & ~({jz, jn, jc} & eff);
                        state_d     = FLUSH;
                        cnt_d       = CNT_INIT;
                        pc_sel_d    = 1'b1;
                        pc_target_d = jmp_target;
                        flush_d     = 1'b1;
                        if (taken_cnt_q != CNT_MAX) begin
                            taken_cnt_d = taken_cnt_q + CNT_ONE;
                        end
                    end else begin
                        pc_sel_d = 1'b0;
                        flush_d  = 1'b0;
                    end
                end
                FLUSH: begin
                    pc_sel_d = 1'b0;
                    if (cnt_q == 3'd0) begin
                        state_d = IDLE;
                        flush_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    pc_sel_d = 1'b0;
                    flush_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            pc_sel_q    <= 1'b0;
            pc_target_q <= '0;
            flush_q     <= 1'b0;
            ccr_q       <= 3'b000;
            taken_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pc_sel_q    <= pc_sel_d;
            pc_target_q <= pc_target_d;
            flush_q     <= flush_d;
            ccr_q       <= ccr_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign ccr       = ccr_q;
    assign pc_sel    = pc_sel_q;
    assign pc_target = pc_target_q;
    assign flush     = flush_q;
    assign busy      = (state_q == FLUSH);
    assign taken_cnt = taken_cnt_q;

endmodule

// File: tb/tb_jump_flush_controller.sv
// ---------------------------------------------------------------------------
// tb_jump_flush_controller
//
// Directed bench for jump_flush_controller. Two instances share all inputs:
// dut (default CNT_W=16) and dut4 (CNT_W=4) for the saturation scenario.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// at that same point, well away from the active edge.
// ---------------------------------------------------------------------------
module tb_jump_flush_controller;

    logic        clk;
    logic        rst;
    logic        jmp_valid, jmp, jz, jn, jc;
    logic [15:0] jmp_target;
    logic        flags_we;
    logic [2:0]  flags_in;
    logic        stall_in;

    logic [2:0]  ccr;
    logic        pc_sel;
    logic [15:0] pc_target;
    logic        flush;
    logic        busy;
    logic [15:0] taken_cnt;

    logic [2:0]  ccr4;
    logic        pc_sel4;
    logic [15:0] pc_target4;
    logic        flush4;
    logic        busy4;
    logic [3:0]  taken_cnt4;

    int total = 0;
    int bad   = 0;

    jump_flush_controller dut (
        .clk(clk), .rst(rst), .jmp_valid(jmp_valid), .jmp(jmp), .jz(jz),
        .jn(jn), .jc(jc), .jmp_target(jmp_target), .flags_we(flags_we),
        .flags_in(flags_in), .stall_in(stall_in), .ccr(ccr), .pc_sel(pc_sel),
        .pc_target(pc_target), .flush(flush), .busy(busy),
        .taken_cnt(taken_cnt)
    );

    jump_flush_controller #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .jmp_valid(jmp_valid), .jmp(jmp), .jz(jz),
        .jn(jn), .jc(jc), .jmp_target(jmp_target), .flags_we(flags_we),
        .flags_in(flags_in), .stall_in(stall_in), .ccr(ccr4),
        .pc_sel(pc_sel4), .pc_target(pc_target4), .flush(flush4),
        .busy(busy4), .taken_cnt(taken_cnt4)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        rst        = 1'b0;
        jmp_valid  = 1'b0;
        jmp        = 1'b0;
        jz         = 1'b0;
        jn         = 1'b0;
        jc         = 1'b0;
        jmp_target = 16'h0000;
        flags_we   = 1'b0;
        flags_in   = 3'b000;
        stall_in   = 1'b0;
    endtask

    // driver: present one jump request for a single cycle
    task automatic drive_jump(input logic u, input logic z, input logic n,
                              input logic c, input logic [15:0] tgt);
        jmp_valid  = 1'b1;
        jmp        = u;
        jz         = z;
        jn         = n;
        jc         = c;
        jmp_target = tgt;
        cyc();
        clear_in();
    endtask

    task automatic set_ccr(input logic [2:0] f);
        flags_we = 1'b1;
        flags_in = f;
        cyc();
        clear_in();
    endtask

    task automatic test_reset();
        clear_in();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        total++;
        if ({pc_sel, flush, busy, ccr, pc_target, taken_cnt} !== 38'd0) begin
            bad++;
            $display("FAIL reset_outputs got pc_sel=%b flush=%b busy=%b ccr=%b tgt=%h cnt=%0d want all 0",
                     pc_sel, flush, busy, ccr, pc_target, taken_cnt);
        end
    endtask

    // T1: unconditional jump, 1-cycle latency, flush for 2 cycles
    task automatic test_uncond();
        drive_jump(1, 0, 0, 0, 16'h0040);
        total++;
        if ({pc_sel, flush, busy} !== 3'b111 || pc_target !== 16'h0040) begin
            bad++;
            $display("FAIL t1_redirect got pc_sel=%b flush=%b busy=%b tgt=%h want 1 1 1 0040",
                     pc_sel, flush, busy, pc_target);
        end
        total++;
        if (taken_cnt !== 16'd1 || ccr !== 3'b000) begin
            bad++;
            $display("FAIL t1_cnt_ccr got cnt=%0d ccr=%b want 1 000", taken_cnt, ccr);
        end
        cyc();
        total++;
        if ({pc_sel, flush, busy} !== 3'b011) begin
            bad++;
            $display("FAIL t1_second_flush got pc_sel=%b flush=%b busy=%b want 0 1 1",
                     pc_sel, flush, busy);
        end
        cyc();
        total++;
        if ({pc_sel, flush, busy} !== 3'b000) begin
            bad++;
            $display("FAIL t1_back_idle got pc_sel=%b flush=%b busy=%b want 0 0 0",
                     pc_sel, flush, busy);
        end
    endtask

    // T2: forwarded Z takes JZ and is consumed; JC with C=0 not taken
    task automatic test_forward();
        flags_we = 1'b1;
        flags_in = 3'b100;
        drive_jump(0, 1, 0, 0, 16'h0100);
        total++;
        if (pc_sel !== 1'b1 || pc_target !== 16'h0100 || ccr !== 3'b000 || taken_cnt !== 16'd2) begin
            bad++;
            $display("FAIL t2_fwd_jz got pc_sel=%b tgt=%h ccr=%b cnt=%0d want 1 0100 000 2",
                     pc_sel, pc_target, ccr, taken_cnt);
        end
        cyc();
        cyc();
        drive_jump(0, 0, 0, 1, 16'h0200);
        total++;
        if ({pc_sel, flush, busy} !== 3'b000 || taken_cnt !== 16'd2) begin
            bad++;
            $display("FAIL t2_jc_not_taken got pc_sel=%b flush=%b busy=%b cnt=%0d want 0 0 0 2",
                     pc_sel, flush, busy, taken_cnt);
        end
    endtask

    // T3: combined conditions, partial flag consumption, request during FLUSH
    task automatic test_multi();
        set_ccr(3'b011);
        total++;
        if (ccr !== 3'b011) begin
            bad++;
            $display("FAIL t3_ccr_write got ccr=%b want 011", ccr);
        end
        drive_jump(0, 0, 1, 1, 16'h0300);
        total++;
        if (pc_sel !== 1'b1 || ccr !== 3'b000 || taken_cnt !== 16'd3) begin
            bad++;
            $display("FAIL t3_jn_jc got pc_sel=%b ccr=%b cnt=%0d want 1 000 3",
                     pc_sel, ccr, taken_cnt);
        end
        // wrong-path request on first FLUSH cycle
        drive_jump(1, 0, 0, 0, 16'h1234);
        total++;
        if ({pc_sel, flush} !== 2'b01 || pc_target !== 16'h0300 || taken_cnt !== 16'd3) begin
            bad++;
            $display("FAIL t3_ignored got pc_sel=%b flush=%b tgt=%h cnt=%0d want 0 1 0300 3",
                     pc_sel, flush, pc_target, taken_cnt);
        end
        cyc();
        total++;
        if (busy !== 1'b0 || taken_cnt !== 16'd3) begin
            bad++;
            $display("FAIL t3_once got busy=%b cnt=%0d want 0 3", busy, taken_cnt);
        end
        // Z,N set; JN alone consumes only N
        set_ccr(3'b110);
        drive_jump(0, 0, 1, 0, 16'h0400);
        total++;
        if (pc_sel !== 1'b1 || ccr !== 3'b100) begin
            bad++;
            $display("FAIL t3_partial_clear got pc_sel=%b ccr=%b want 1 100", pc_sel, ccr);
        end
        cyc();
        cyc();
        // JMP leaves flags alone
        drive_jump(1, 0, 0, 0, 16'h0500);
        total++;
        if (pc_sel !== 1'b1 || ccr !== 3'b100 || taken_cnt !== 16'd5) begin
            bad++;
            $display("FAIL t3_jmp_keeps_ccr got pc_sel=%b ccr=%b cnt=%0d want 1 100 5",
                     pc_sel, ccr, taken_cnt);
        end
        cyc();
        cyc();
    endtask

    // T4: stall during FLUSH, plus stall blocking accept and ccr writes
    task automatic test_stall();
        drive_jump(1, 0, 0, 0, 16'h00A0);
        stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({pc_sel, flush, busy} !== 3'b111) begin
                bad++;
                $display("FAIL t4_stall_hold%0d got pc_sel=%b flush=%b busy=%b want 1 1 1",
                         i, pc_sel, flush, busy);
            end
            cyc();
        end
        stall_in = 1'b0;
        total++;
        if ({pc_sel, flush} !== 2'b11 || taken_cnt !== 16'd6) begin
            bad++;
            $display("FAIL t4_pc_sel_4th got pc_sel=%b flush=%b cnt=%0d want 1 1 6",
                     pc_sel, flush, taken_cnt);
        end
        cyc();
        total++;
        if ({pc_sel, flush} !== 2'b01) begin
            bad++;
            $display("FAIL t4_flush_last got pc_sel=%b flush=%b want 0 1", pc_sel, flush);
        end
        cyc();
        total++;
        if ({flush, busy} !== 2'b00) begin
            bad++;
            $display("FAIL t4_done got flush=%b busy=%b want 0 0", flush, busy);
        end
        // stalled request in IDLE and stalled flag write have no effect
        stall_in = 1'b1;
        flags_we = 1'b1;
        flags_in = 3'b001;
        drive_jump(1, 0, 0, 0, 16'h0BAD);
        total++;
        if ({pc_sel, flush, busy} !== 3'b000 || ccr !== 3'b100 || taken_cnt !== 16'd6) begin
            bad++;
            $display("FAIL t4_stall_idle got pc_sel=%b flush=%b busy=%b ccr=%b cnt=%0d want 0 0 0 100 6",
                     pc_sel, flush, busy, ccr, taken_cnt);
        end
    endtask

    // T5: reset on the first FLUSH cycle
    task automatic test_reset_mid();
        drive_jump(1, 0, 0, 0, 16'h0777);
        total++;
        if (pc_sel !== 1'b1) begin
            bad++;
            $display("FAIL t5_pre got pc_sel=%b want 1", pc_sel);
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        total++;
        if ({pc_sel, flush, busy, ccr, pc_target, taken_cnt} !== 38'd0) begin
            bad++;
            $display("FAIL t5_reset_mid got pc_sel=%b flush=%b busy=%b ccr=%b tgt=%h cnt=%0d want all 0",
                     pc_sel, flush, busy, ccr, pc_target, taken_cnt);
        end
    endtask

    // saturation of the 4-bit counter after 17 taken jumps
    task automatic test_saturation();
        for (int i = 1; i <= 17; i++) begin
            drive_jump(1, 0, 0, 0, 16'(i));
            cyc();
            cyc();
            if (i == 14) begin
                total++;
                if (taken_cnt4 !== 4'hE) begin
                    bad++;
                    $display("FAIL sat_14 got cnt4=%h want e", taken_cnt4);
                end
            end
            if (i == 15) begin
                total++;
                if (taken_cnt4 !== 4'hF) begin
                    bad++;
                    $display("FAIL sat_15 got cnt4=%h want f", taken_cnt4);
                end
            end
        end
        total++;
        if (taken_cnt4 !== 4'hF || taken_cnt !== 16'd17) begin
            bad++;
            $display("FAIL sat_17 got cnt4=%h cnt16=%0d want f 17", taken_cnt4, taken_cnt);
        end
    endtask

    initial begin
        clear_in();
        test_reset();
        test_uncond();
        test_forward();
        test_multi();
        test_stall();
        test_reset_mid();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
